skid_buffer: RTL and testbench



---
 rtl/skid_buffer.sv | 173 +++++++++++++++++
 tb/tb_skid_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//
// Two-entry registered pipeline stage for a DW-bit payload on a valid/ready
// handshake. Both o_valid and i_ready come straight from flops, so this stage
// breaks the combinational o_ready -> i_ready path without losing throughput.
//
// Storage is a main register (drives o_data) and a skid register that catches
// the one beat accepted in the cycle the downstream side first stalls.
//
// Optional feature macro: SKID_BUFFER_STAT_EN
//   When defined, adds the 32-bit saturating stall counter o_stall_cnt, which
//   counts every edge with o_valid && !o_ready and is cleared only by reset.
//   When undefined, neither the port nor the counter exists.
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data
`ifdef SKID_BUFFER_STAT_EN
    ,
    output logic [31:0]   o_stall_cnt
`endif
);

    // Occupancy: EMPTY = nothing held, ONE = main holds the head beat,
    // FULL = main holds the head beat and skid holds the next one.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;

    logic [DW-1:0] main_r;
    logic [DW-1:0] skid_r;
    logic [DW-1:0] main_next_s;
    logic [DW-1:0] skid_next_s;

    logic          o_valid_r;
    logic          i_ready_r;
    logic          o_valid_next_s;
    logic          i_ready_next_s;

    // Data-path steering decided by the next-state logic.
    logic          load_main_in_s;    // main <- i_data
    logic          load_main_skid_s;  // main <- skid
    logic          load_skid_in_s;    // skid <- i_data

    // State register: async clear discards any buffered beats at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: pushes are only possible while i_ready is high,
    // which the flag register guarantees for EMPTY and ONE only.
    always_comb begin
        state_next_s     = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_in_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (i_valid) begin
                    state_next_s   = ST_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_next_s   = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (i_valid && o_ready) begin
                    // Simultaneous pop and push: new beat replaces the head.
                    state_next_s   = ST_ONE;
                    load_main_in_s = 1'b1;
                end else if (i_valid && !o_ready) begin
                    // Downstream stalled while a beat arrives: catch it in skid.
                    state_next_s   = ST_FULL;
                    load_skid_in_s = 1'b1;
                end else if (!i_valid && o_ready) begin
                    state_next_s   = ST_EMPTY;
                end else begin
                    state_next_s   = ST_ONE;
                end
            end
            ST_FULL: begin
                if (o_ready) begin
                    // Head leaves; the skid beat moves forward into main.
                    state_next_s     = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_next_s     = ST_FULL;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean empty buffer.
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Output decode: flags and register contents for the next cycle,
    // derived only from the next state and the steering strobes.
    always_comb begin
        o_valid_next_s = (state_next_s != ST_EMPTY);
        i_ready_next_s = (state_next_s != ST_FULL);

        if (load_main_in_s) begin
            main_next_s = i_data;
        end else if (load_main_skid_s) begin
            main_next_s = skid_r;
        end else begin
            main_next_s = main_r;
        end

        if (load_skid_in_s) begin
            skid_next_s = i_data;
        end else begin
            skid_next_s = skid_r;
        end
    end

    // Output and storage registers: no combinational path from any input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid_r <= 1'b0;
            i_ready_r <= 1'b1;
            main_r    <= {DW{1'b0}};
            skid_r    <= {DW{1'b0}};
        end else begin
            o_valid_r <= o_valid_next_s;
            i_ready_r <= i_ready_next_s;
            main_r    <= main_next_s;
            skid_r    <= skid_next_s;
        end
    end

    assign o_valid = o_valid_r;
    assign i_ready = i_ready_r;
    assign o_data  = main_r;

`ifdef SKID_BUFFER_STAT_EN
    logic [31:0] stall_cnt_r;

    // Stall counter: counts edges where a beat is offered but not taken,
    // sticks at all-ones, and is cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
        end else if (o_valid_r && !o_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer
//
// Directed and randomized stimulus for skid_buffer. The reference model is a
// two-deep FIFO held as a queue: o_valid is "queue not empty", i_ready is
// "queue holds fewer than two beats", o_data is the queue head. Outputs are
// sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Define SKID_BUFFER_STAT_EN to also check the stall counter.
// -----------------------------------------------------------------------------
module tb_skid_buffer;

    localparam int DW = 256;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
`ifdef SKID_BUFFER_STAT_EN
    logic [31:0]   o_stall_cnt;
`endif

    int            vectors;
    int            miscompares;
    logic [DW-1:0] q[$];
    logic [31:0]   stall_exp;

    skid_buffer #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data)
`ifdef SKID_BUFFER_STAT_EN
        ,
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against the FIFO model (called at the falling edge).
    task automatic check_outputs(input string tag);
        chk1({tag, ".o_valid"}, o_valid, q.size() > 0);
        chk1({tag, ".i_ready"}, i_ready, q.size() < 2);
        if (q.size() > 0) begin
            chkw({tag, ".o_data"}, o_data, q[0]);
        end
`ifdef SKID_BUFFER_STAT_EN
        chkw({tag, ".stall_cnt"}, DW'(o_stall_cnt), DW'(stall_exp));
`endif
    endtask

    // One clock cycle: drive inputs, check at the falling edge, then advance
    // the model by the handshakes that complete on the rising edge.
    task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] d, input logic ordy);
        logic push;
        logic pop;
        i_valid = iv;
        i_data  = d;
        o_ready = ordy;
        @(negedge clk);
        check_outputs(tag);
        pop  = (q.size() > 0) && ordy;
        push = iv && (q.size() < 2);
        if ((q.size() > 0) && !ordy && (stall_exp != 32'hFFFF_FFFF)) begin
            stall_exp = stall_exp + 32'd1;
        end
        @(posedge clk);
        #1;
        if (pop) begin
            void'(q.pop_front());
        end
        if (push) begin
            q.push_back(d);
        end
    endtask

    initial begin
        int n_push;
        int guard;
        vectors     = 0;
        miscompares = 0;
        stall_exp   = 32'd0;
        rst         = 1'b0;
        i_valid     = 1'b0;
        i_data      = {DW{1'b0}};
        o_ready     = 1'b0;

        // Reset, then idle.
        #23;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("reset.o_valid", o_valid, 1'b0);
        chk1("reset.i_ready", i_ready, 1'b1);
        chkw("reset.o_data", o_data, {DW{1'b0}});
        for (int k = 0; k < 10; k++) begin
            cycle("idle", 1'b0, rand_word(), k[0]);
            chkw("idle.o_data", o_data, {DW{1'b0}});
        end

        // Streaming 0x1..0x8 with o_ready held high.
        for (int k = 1; k <= 8; k++) begin
            cycle("stream", 1'b1, DW'(k), 1'b1);
        end
        cycle("stream_tail", 1'b0, rand_word(), 1'b1);
        chkw("stream.last", o_data, DW'(32'h0000_0008));
        cycle("stream_tail", 1'b0, rand_word(), 1'b1);

        // Backpressure fill: A and B accepted, C held upstream.
        cycle("bp", 1'b1, DW'(32'h0000_000A), 1'b0);
        cycle("bp", 1'b1, DW'(32'h0000_000B), 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle("bp_full", 1'b1, DW'(32'h0000_000C), 1'b0);
            chk1("bp.i_ready_low", i_ready, 1'b0);
            chkw("bp.stable_a", o_data, DW'(32'h0000_000A));
        end
        cycle("bp_drain", 1'b1, DW'(32'h0000_000C), 1'b1);
        chkw("bp.second_b", o_data, DW'(32'h0000_000B));
        cycle("bp_drain", 1'b1, DW'(32'h0000_000C), 1'b1);
        chkw("bp.third_c", o_data, DW'(32'h0000_000C));
        cycle("bp_drain", 1'b0, rand_word(), 1'b1);
        cycle("bp_drain", 1'b0, rand_word(), 1'b1);

        // Random valid/ready, 1000 accepted beats.
        n_push = 0;
        guard  = 0;
        while ((n_push < 1000) && (guard < 20000)) begin
            logic iv;
            logic ordy;
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            if (iv && (q.size() < 2)) begin
                n_push++;
            end
            cycle("rand", iv, rand_word(), ordy);
            guard++;
        end
        if (n_push < 1000) begin
            miscompares++;
            $error("FAIL rand_budget: observed %0d beats expected 1000", n_push);
        end
        for (int k = 0; k < 4; k++) begin
            cycle("rand_drain", 1'b0, rand_word(), 1'b1);
        end

        // Reset while FULL: both held beats are discarded.
        cycle("rf_fill", 1'b1, rand_word(), 1'b0);
        cycle("rf_fill", 1'b1, rand_word(), 1'b0);
        chk1("rf.full", i_ready, 1'b0);
        #3;
        rst     = 1'b0;
        i_valid = 1'b0;
        #1;
        chk1("rf.o_valid_async", o_valid, 1'b0);
        chk1("rf.i_ready_async", i_ready, 1'b1);
        chkw("rf.o_data_async", o_data, {DW{1'b0}});
        q.delete();
        stall_exp = 32'd0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            cycle("rf_after", 1'b0, rand_word(), 1'b1);
            chkw("rf.o_data_after", o_data, {DW{1'b0}});
        end

`ifdef SKID_BUFFER_STAT_EN
        // Stall counter: one beat held five cycles, then popped.
        cycle("stall_push", 1'b1, DW'(32'h0000_0055), 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle("stall_hold", 1'b0, rand_word(), 1'b0);
        end
        cycle("stall_pop", 1'b0, rand_word(), 1'b1);
        cycle("stall_after", 1'b0, rand_word(), 1'b1);
        chkw("stall.count", DW'(o_stall_cnt), DW'(32'd5));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
